rr_stream_mux: RTL

Parametrised N-to-1 stream multiplexer with round-robin arbitration and a registered output stage. It generalises the datapath 2:1 select mux to NUM_CH valid/ready channels. It sits between multiple producers (e.g. MMIO/UART/counter response paths) and a single consumer, forwarding one beat per cycle with fair access.

---
 rtl/rr_stream_mux.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-to-1 round-robin stream mux with registered output (optional packet lock: MUX_LOCK_EN)
//
// Optional feature macro: MUX_LOCK_EN
//   defined   : in_last/out_last ports exist and a two-state lock FSM keeps
//               a packet's beats together on the output.
//   undefined : arbitration is per beat; no lock state, no last signals.

module rr_stream_mux #(
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_CH     = 4,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch,
`ifdef MUX_LOCK_EN
  input  logic [NUM_CH-1:0]            in_last,
  output logic                         out_last,
`endif
  input  logic                         out_ready
);

  // Output register and arbiter pointer
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]      out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]      rr_ptr_q,    rr_ptr_d;

  // Arbitration signals
  logic [NUM_CH-1:0]     eligible;
  logic                  grant_valid;
  logic [SEL_W-1:0]      grant_idx;
  logic [SEL_W-1:0]      cand_sel;
  int                    cand;
  logic                  load_en;
  logic                  load;
  logic [DATA_WIDTH-1:0] ch_data [NUM_CH];

`ifdef MUX_LOCK_EN
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state_q,    state_d;
  logic [SEL_W-1:0] lock_ch_q,  lock_ch_d;
  logic             out_last_q, out_last_d;
`endif

  // Split the flat input bus into one word per channel
  for (genvar i = 0; i < NUM_CH; i++) begin : g_split
    assign ch_data[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // The output stage can take a new beat when empty or draining this cycle
  assign load_en = !out_valid_q || out_ready;
  assign load    = load_en && grant_valid;

  // Channels allowed to compete: all of them, or only the locked owner mid-packet
  always_comb begin
    eligible = in_valid;
`ifdef MUX_LOCK_EN
    if (state_q == S_LOCKED) begin
      eligible            = '0;
      eligible[lock_ch_q] = in_valid[lock_ch_q];
    end
`endif
  end

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_sel    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand     = (int'(rr_ptr_q) + k) % NUM_CH;
      cand_sel = SEL_W'(cand);
      if (!grant_valid && eligible[cand_sel]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_sel;
      end
    end
  end

  // One-hot accept toward the granted producer, only when the beat is taken
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = load && (grant_idx == SEL_W'(i));
    end
  end

  // Next state of the output register and pointer; data/channel hold when draining
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
      rr_ptr_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer state; reset gives channel 0 first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef MUX_LOCK_EN
  // Lock FSM next state: a non-last beat claims the output until its last beat
  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    out_last_d = out_last_q;
    if (load) begin
      out_last_d = in_last[grant_idx];
    end
    case (state_q)
      S_IDLE: begin
        if (load && !in_last[grant_idx]) begin
          state_d   = S_LOCKED;
          lock_ch_d = grant_idx;
        end
      end
      S_LOCKED: begin
        if (load && in_last[grant_idx]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lock FSM state and registered last flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

endmodule
